// File: rtl/medidor_desempenho_pkg.sv
// Shared types and helpers for the memory tester: FSM state encoding,
// mode constants, error counter width and the test pattern generator.
package medidor_desempenho_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        READ  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic MODE_FILL  = 1'b0;
    localparam logic MODE_CHECK = 1'b1;

    localparam int ERR_W = 16;

    // Word i of a test run carries seed + i (32-bit wrap).
    function automatic logic [31:0] pattern(input logic [31:0] seed, input logic [31:0] idx);
        return seed + idx;
    endfunction

endpackage

// File: rtl/medidor_desempenho_sat_counter.sv
// Up-counter that clears on request and sticks at all-ones instead of wrapping.
module medidor_desempenho_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Clear wins over enable so a new run always starts from zero.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/medidor_desempenho_mem_tester.sv
// Avalon-MM master that fills a word range with seed + i or reads it back
// and compares, reporting bus cycles used, mismatches and the first bad index.
//
// Bus handshake: a command (avm_read or avm_write) is taken by the slave on
// every cycle where it is high and avm_waitrequest is low; while
// avm_waitrequest is high the command, address and data are held unchanged.
// Read data returns later, one word per avm_readdatavalid, in request order.
module medidor_desempenho_mem_tester
    import medidor_desempenho_pkg::*;
#(
    parameter int ADDR_W   = 13,
    parameter int CNT_W    = 12,
    parameter int MAX_PEND = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  word_count,
    input  logic [31:0]       seed,
    output logic              busy,
    output logic              done,
    output logic [ERR_W-1:0]  err_count,
    output logic [CNT_W-1:0]  first_err_idx,
    output logic [31:0]       cycle_count,
    output logic [ADDR_W-1:0] avm_address,
    output logic [3:0]        avm_byteenable,
    output logic              avm_read,
    output logic              avm_write,
    output logic [31:0]       avm_writedata,
    input  logic              avm_waitrequest,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_readdatavalid
);

    localparam int WORD_W = ADDR_W - 2;
    localparam int PEND_W = $clog2(MAX_PEND + 1);
    localparam logic [PEND_W-1:0] PEND_LIMIT = PEND_W'(MAX_PEND);

    // Registered state
    state_t              state_q,     state_d;
    logic                mode_q,      mode_d;
    logic [WORD_W-1:0]   base_q,      base_d;
    logic [CNT_W-1:0]    count_q,     count_d;
    logic [31:0]         seed_q,      seed_d;
    logic [CNT_W-1:0]    cmd_idx_q,   cmd_idx_d;
    logic [CNT_W-1:0]    ret_idx_q,   ret_idx_d;
    logic [PEND_W-1:0]   pend_q,      pend_d;
    logic                busy_q,      busy_d;
    logic                done_q,      done_d;
    logic [CNT_W-1:0]    first_err_q, first_err_d;

    // Combinational helpers
    logic                start_ok;
    logic                wr_acc;
    logic                rd_acc;
    logic                last_cmd;
    logic                rdv_act;
    logic                mismatch;
    logic [WORD_W-1:0]   cmd_word;
    logic [ERR_W-1:0]    err_count_w;
    logic [31:0]         cycle_count_w;
    logic                unused_base_lsbs;

    // Byte lanes below word granularity are not used by a word-only master.
    assign unused_base_lsbs = ^base_addr[1:0];

    assign start_ok = start && (state_q == IDLE);
    assign cmd_word = base_q + WORD_W'(cmd_idx_q);
    assign last_cmd = (cmd_idx_q == (count_q - CNT_W'(1)));
    assign wr_acc   = avm_write && !avm_waitrequest;
    assign rd_acc   = avm_read && !avm_waitrequest;
    assign rdv_act  = avm_readdatavalid && ((state_q == READ) || (state_q == DRAIN));
    assign mismatch = rdv_act && (avm_readdata != pattern(seed_q, 32'(ret_idx_q)));

    // Bus command outputs; reads throttle once MAX_PEND are in flight.
    always_comb begin
        avm_write      = 1'b0;
        avm_read       = 1'b0;
        avm_address    = '0;
        avm_byteenable = 4'h0;
        avm_writedata  = '0;
        if (state_q == WRITE) begin
            avm_write = 1'b1;
        end else if ((state_q == READ) && (pend_q < PEND_LIMIT)) begin
            avm_read = 1'b1;
        end
        if (avm_write || avm_read) begin
            avm_address    = {cmd_word, 2'b00};
            avm_byteenable = 4'hF;
        end
        if (avm_write) begin
            avm_writedata = pattern(seed_q, 32'(cmd_idx_q));
        end
    end

    // Next-state logic for the run sequencer.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start_ok) begin
                    if (word_count == '0) begin
                        state_d = DONE;
                    end else if (mode == MODE_CHECK) begin
                        state_d = READ;
                    end else begin
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                if (wr_acc && last_cmd) state_d = DONE;
            end
            READ: begin
                if (rd_acc && last_cmd) state_d = DRAIN;
            end
            DRAIN: begin
                if (pend_q == '0) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Run configuration, indices, outstanding-read tracking and status flags.
    always_comb begin
        mode_d      = mode_q;
        base_d      = base_q;
        count_d     = count_q;
        seed_d      = seed_q;
        cmd_idx_d   = cmd_idx_q;
        ret_idx_d   = ret_idx_q;
        pend_d      = pend_q;
        busy_d      = busy_q;
        first_err_d = first_err_q;
        done_d      = (state_q == DONE);

        if (start_ok) begin
            mode_d      = mode;
            base_d      = base_addr[ADDR_W-1:2];
            count_d     = word_count;
            seed_d      = seed;
            cmd_idx_d   = '0;
            ret_idx_d   = '0;
            pend_d      = '0;
            busy_d      = 1'b1;
            first_err_d = '0;
        end else begin
            if (wr_acc || rd_acc) begin
                cmd_idx_d = cmd_idx_q + CNT_W'(1);
            end
            if (rdv_act) begin
                ret_idx_d = ret_idx_q + CNT_W'(1);
            end
            // Accept and return in the same cycle cancel out.
            if (rd_acc && !rdv_act) begin
                pend_d = pend_q + PEND_W'(1);
            end else if (!rd_acc && rdv_act && (pend_q != '0)) begin
                pend_d = pend_q - PEND_W'(1);
            end
            // Only the first mismatch of a run is recorded.
            if (mismatch && (err_count_w == '0)) begin
                first_err_d = ret_idx_q;
            end
            if (state_q == DONE) begin
                busy_d = 1'b0;
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            mode_q      <= MODE_FILL;
            base_q      <= '0;
            count_q     <= '0;
            seed_q      <= '0;
            cmd_idx_q   <= '0;
            ret_idx_q   <= '0;
            pend_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            first_err_q <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            base_q      <= base_d;
            count_q     <= count_d;
            seed_q      <= seed_d;
            cmd_idx_q   <= cmd_idx_d;
            ret_idx_q   <= ret_idx_d;
            pend_q      <= pend_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            first_err_q <= first_err_d;
        end
    end

    medidor_desempenho_sat_counter #(
        .WIDTH (ERR_W)
    ) u_err_counter (
        .clk    (clk),
        .reset  (reset),
        .clear  (start_ok),
        .enable (mismatch),
        .count  (err_count_w)
    );

    medidor_desempenho_sat_counter #(
        .WIDTH (32)
    ) u_cycle_counter (
        .clk    (clk),
        .reset  (reset),
        .clear  (start_ok),
        .enable (busy_q),
        .count  (cycle_count_w)
    );

    assign busy          = busy_q;
    assign done          = done_q;
    assign err_count     = err_count_w;
    assign first_err_idx = first_err_q;
    assign cycle_count   = cycle_count_w;

    // The latched mode is implied by the active state; kept for visibility.
    logic unused_mode_q;
    assign unused_mode_q = mode_q;

endmodule
